mem_bank_rv: RTL and testbench

Parametrised single-port memory bank with a valid/ready request channel and a registered response channel. It replaces the fixed 8×16 memory as the standard storage block for the design. It adds configurable width and depth, byte-lane write strobes, an out-of-range error response, and an optional post-reset zero-initialisation sweep. It accepts one request per cycle and returns one response per accepted request, one cycle later.

---
 rtl/mem_pkg.sv | 17 +
 rtl/mem_array.sv | 32 +++
 rtl/mem_bank_rv.sv | 118 +++++++++++
 tb/tb_mem_bank_rv.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the mem_bank_rv storage block: FSM states, request
// opcodes and the byte-lane count helper.
package mem_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic OP_WRITE = 1'b1;
    localparam logic OP_READ  = 1'b0;

    function automatic int lane_count(input int width);
        return width / 8;
    endfunction

endpackage

// File: rtl/mem_array.sv
// DEPTH x WIDTH storage with a byte-enabled synchronous write port and a
// registered read port. The array itself is never reset.
module mem_array #(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic [WIDTH/8-1:0]    wstrb,
    output logic [WIDTH-1:0]      rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // rdata only moves on a read, so it holds between read responses
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int k = 0; k < WIDTH / 8; k++) begin
                    if (wstrb[k]) mem[addr][8*k +: 8] <= wdata[8*k +: 8];
                end
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/mem_bank_rv.sv
// Single-port memory bank with valid/ready requests and a one-cycle registered
// response. Define MEM_BANK_INIT_EN to add the post-reset zero-fill sweep.
//
// state   | meaning
// INIT    | zero-fill sweep, one word per cycle, ready held low
// RUN     | accepting one request per cycle, no backpressure
module mem_bank_rv
    import mem_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid,
    output logic                  ready,
    input  logic                  wr_rd,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic [WIDTH/8-1:0]    wstrb,
    output logic [WIDTH-1:0]      rdata,
    output logic                  resp_valid,
    output logic                  err
);

    localparam int                    LANES   = lane_count(WIDTH);
    localparam logic [ADDR_WIDTH:0]   DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST    = ADDR_WIDTH'(DEPTH - 1);

    state_t                state;
    logic                  init_phase;
    logic [ADDR_WIDTH-1:0] init_addr;
    logic                  accept;
    logic                  in_range;
    logic                  rd_sel;
    logic                  arr_en;
    logic                  arr_we;
    logic [ADDR_WIDTH-1:0] arr_addr;
    logic [WIDTH-1:0]      arr_wdata;
    logic [LANES-1:0]      arr_wstrb;
    logic [WIDTH-1:0]      arr_q;

`ifdef MEM_BANK_INIT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_INIT;
            init_addr <= '0;
            ready     <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    ready <= 1'b0;
                    if (init_addr == LAST) state <= ST_RUN;
                    else                   init_addr <= init_addr + 1'b1;
                end
                ST_RUN:  ready <= 1'b1;
                default: state <= ST_INIT;
            endcase
        end
    end

    assign init_phase = (state == ST_INIT);
`else
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_RUN;
            ready <= 1'b0;
        end else begin
            state <= ST_RUN;
            ready <= (state == ST_RUN);
        end
    end

    assign init_phase = 1'b0;
    assign init_addr  = '0;
`endif

    assign accept   = valid & ready;
    assign in_range = {1'b0, addr} < DEPTH_L;

    // the sweep owns the array port while ready is low, so no arbitration needed
    assign arr_en    = init_phase | (accept & in_range);
    assign arr_we    = init_phase | (wr_rd == OP_WRITE);
    assign arr_addr  = init_phase ? init_addr : addr;
    assign arr_wdata = init_phase ? '0 : wdata;
    assign arr_wstrb = init_phase ? '1 : wstrb;

    mem_array #(
        .WIDTH      (WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_array (
        .clk   (clk),
        .en    (arr_en),
        .we    (arr_we),
        .addr  (arr_addr),
        .wdata (arr_wdata),
        .wstrb (arr_wstrb),
        .rdata (arr_q)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            resp_valid <= 1'b0;
            err        <= 1'b0;
            rd_sel     <= 1'b0;
        end else begin
            resp_valid <= accept;
            err        <= accept & ~in_range;
            if (accept) rd_sel <= in_range & (wr_rd == OP_READ);
        end
    end

    // write and error responses present zero; read data holds until next response
    assign rdata = rd_sel ? arr_q : '0;

endmodule

// File: tb/tb_mem_bank_rv.sv
// Directed self-checking bench for mem_bank_rv: a default 8x16 bank and a
// 32-bit x 12-word bank sharing clock and reset.
module tb_mem_bank_rv;

`ifdef MEM_BANK_INIT_EN
    localparam int EXP_RDY_D = 17;
    localparam int EXP_RDY_A = 13;
`else
    localparam int EXP_RDY_D = 1;
    localparam int EXP_RDY_A = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic       d_valid = 1'b0, d_wr_rd = 1'b0, d_ready, d_resp_valid, d_err;
    logic [3:0] d_addr = '0;
    logic [7:0] d_wdata = '0, d_rdata;
    logic [0:0] d_wstrb = '0;

    logic        a_valid = 1'b0, a_wr_rd = 1'b0, a_ready, a_resp_valid, a_err;
    logic [3:0]  a_addr = '0;
    logic [31:0] a_wdata = '0, a_rdata;
    logic [3:0]  a_wstrb = '0;

    int total = 0;
    int bad   = 0;

    mem_bank_rv #(.WIDTH(8), .DEPTH(16), .ADDR_WIDTH(4)) u_d (
        .clk(clk), .rst(rst), .valid(d_valid), .ready(d_ready), .wr_rd(d_wr_rd),
        .addr(d_addr), .wdata(d_wdata), .wstrb(d_wstrb), .rdata(d_rdata),
        .resp_valid(d_resp_valid), .err(d_err)
    );

    mem_bank_rv #(.WIDTH(32), .DEPTH(12), .ADDR_WIDTH(4)) u_a (
        .clk(clk), .rst(rst), .valid(a_valid), .ready(a_ready), .wr_rd(a_wr_rd),
        .addr(a_addr), .wdata(a_wdata), .wstrb(a_wstrb), .rdata(a_rdata),
        .resp_valid(a_resp_valid), .err(a_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic req_d(input logic wr, input logic [3:0] ad, input logic [7:0] wd, input logic st);
        d_valid = 1'b1; d_wr_rd = wr; d_addr = ad; d_wdata = wd; d_wstrb = st;
        @(posedge clk); #1;
    endtask

    task automatic req_a(input logic wr, input logic [3:0] ad, input logic [31:0] wd, input logic [3:0] st);
        a_valid = 1'b1; a_wr_rd = wr; a_addr = ad; a_wdata = wd; a_wstrb = st;
        @(posedge clk); #1;
    endtask

    task automatic idle();
        d_valid = 1'b0; a_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic wait_ready();
        int nd = 0;
        int na = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (nd == 0 && d_ready) nd = n;
            if (na == 0 && a_ready) na = n;
        end
        chk("rdy_edges_d", nd, EXP_RDY_D);
        chk("rdy_edges_a", na, EXP_RDY_A);
    endtask

    initial begin
        #12;
        chk("rst_ready_d", d_ready, 0);
        chk("rst_resp_valid_d", d_resp_valid, 0);
        chk("rst_err_d", d_err, 0);
        chk("rst_rdata_d", d_rdata, 0);
        chk("rst_ready_a", a_ready, 0);
        @(negedge clk) rst = 1'b1;
        wait_ready();

`ifdef MEM_BANK_INIT_EN
        for (int i = 0; i < 16; i++) begin
            req_d(1'b0, 4'(i), 8'h00, 1'b0);
            chk("init_zero_rdata", d_rdata, 0);
            chk("init_zero_err", d_err, 0);
        end
        idle();
`endif

        // byte write then back-to-back read
        req_d(1'b1, 4'd3, 8'hA5, 1'b1);
        chk("wr_resp_valid", d_resp_valid, 1);
        chk("wr_rdata_zero", d_rdata, 0);
        chk("wr_err", d_err, 0);
        req_d(1'b0, 4'd3, 8'h00, 1'b0);
        chk("rd_resp_valid", d_resp_valid, 1);
        chk("rd_rdata", d_rdata, 8'hA5);
        chk("rd_err", d_err, 0);
        idle();
        chk("idle_resp_valid", d_resp_valid, 0);
        chk("idle_rdata_hold", d_rdata, 8'hA5);

        // lane strobes on the wide bank, including an all-zero strobe
        req_a(1'b1, 4'd2, 32'h11223344, 4'hF);
        req_a(1'b1, 4'd2, 32'hFFFFFFFF, 4'b0101);
        req_a(1'b0, 4'd2, 32'h0, 4'h0);
        chk("strb_rdata", a_rdata, 32'h11FF33FF);
        req_a(1'b1, 4'd2, 32'h00000000, 4'h0);
        chk("strb0_resp_valid", a_resp_valid, 1);
        chk("strb0_err", a_err, 0);
        req_a(1'b0, 4'd2, 32'h0, 4'h0);
        chk("strb0_rdata", a_rdata, 32'h11FF33FF);

        // out-of-range accesses on the 12-word bank
        req_a(1'b1, 4'd11, 32'hCAFEBABE, 4'hF);
        req_a(1'b1, 4'd13, 32'h00000055, 4'hF);
        chk("oor_wr_err", a_err, 1);
        chk("oor_wr_rdata", a_rdata, 0);
        req_a(1'b0, 4'd13, 32'h0, 4'h0);
        chk("oor_rd_resp_valid", a_resp_valid, 1);
        chk("oor_rd_err", a_err, 1);
        chk("oor_rd_rdata", a_rdata, 0);
        req_a(1'b0, 4'd11, 32'h0, 4'h0);
        chk("inrange_rd_err", a_err, 0);
        chk("inrange_rd_rdata", a_rdata, 32'hCAFEBABE);
        idle();

        // 16 writes then 16 reads with valid held high
        for (int i = 0; i < 16; i++) begin
            req_d(1'b1, 4'(i), 8'(i * 7 + 1), 1'b1);
            chk("stream_wr_resp_valid", d_resp_valid, 1);
        end
        for (int i = 0; i < 16; i++) begin
            req_d(1'b0, 4'(i), 8'h00, 1'b0);
            chk("stream_rd_resp_valid", d_resp_valid, 1);
            chk("stream_rd_rdata", d_rdata, 8'(i * 7 + 1));
        end
        idle();
        chk("stream_end_resp_valid", d_resp_valid, 0);

        // reset mid-stream with an error response in flight
        req_d(1'b0, 4'd5, 8'h00, 1'b0);
        req_a(1'b0, 4'd14, 32'h0, 4'h0);
        chk("pre_rst_err", a_err, 1);
        rst = 1'b0;
        #1;
        chk("midrst_resp_valid_a", a_resp_valid, 0);
        chk("midrst_err_a", a_err, 0);
        chk("midrst_ready_a", a_ready, 0);
        chk("midrst_ready_d", d_ready, 0);
        chk("midrst_rdata_d", d_rdata, 0);
        d_valid = 1'b0; a_valid = 1'b0;
        @(posedge clk);
        @(negedge clk) rst = 1'b1;
        wait_ready();
`ifdef MEM_BANK_INIT_EN
        req_d(1'b0, 4'd3, 8'h00, 1'b0);
        chk("post_rst_zero", d_rdata, 0);
        idle();
`endif

        // reset again a few cycles after release
        @(negedge clk) rst = 1'b0;
        @(negedge clk) rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("early_ready_d", d_ready, (EXP_RDY_D <= 5) ? 1 : 0);
        @(negedge clk) rst = 1'b0;
        #1;
        chk("rerst_ready_d", d_ready, 0);
        @(negedge clk) rst = 1'b1;
        wait_ready();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
